disp_frame_rd_ctrl: RTL and testbench



---
 rtl/disp_frame_rd_ctrl_pkg.sv | 13 +
 rtl/disp_rd_addr_gen.sv | 37 +++
 rtl/disp_frame_rd_ctrl.sv | 109 ++++++++++
 tb/tb_disp_frame_rd_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/disp_frame_rd_ctrl_pkg.sv
// disp_frame_rd_ctrl_pkg: shared widths, tag bit positions and FSM encoding for the display read path
package disp_frame_rd_ctrl_pkg;
    localparam int DSIZE   = 34;
    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;
    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_WAIT = 5'b00010,
        S_REQ  = 5'b00100,
        S_DATA = 5'b01000,
        S_FEND = 5'b10000
    } state_t;
endpackage

// File: rtl/disp_rd_addr_gen.sv
// disp_rd_addr_gen: frame word counter, burst address/length and first/last-word flags
module disp_rd_addr_gen #(
    parameter int FRAME_WORDS = 128000,
    parameter int BURST_LEN   = 32,
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic              sel,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic [ADDR_W-1:0] addr,
    output logic [LEN_W-1:0]  len,
    output logic              first,
    output logic              last
);
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] rem;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            word_cnt <= '0;
        else if (clr)
            word_cnt <= '0;
        else if (inc)
            word_cnt <= word_cnt + 1'b1;
    end
    // final burst shrinks to the words left so reads never pass base+FRAME_WORDS
    assign rem   = CNT_W'(FRAME_WORDS) - word_cnt;
    assign len   = (32'(rem) >= BURST_LEN) ? LEN_W'(BURST_LEN) : LEN_W'(rem);
    assign addr  = (sel ? base_b : base_a) + ADDR_W'(word_cnt);
    assign first = word_cnt == '0;
    assign last  = word_cnt == CNT_W'(FRAME_WORDS - 1);
endmodule

// File: rtl/disp_frame_rd_ctrl.sv
// disp_frame_rd_ctrl: paced burst reads of a ping-pong frame buffer into the display FIFO
module disp_frame_rd_ctrl
    import disp_frame_rd_ctrl_pkg::*;
#(
    parameter int FRAME_WORDS = 128000,
    parameter int BURST_LEN   = 32,
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic              wr_frame_done,
    input  logic              disp_fifo_rdy,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [LEN_W-1:0]  mem_rd_len,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_vld,
    input  logic [31:0]       mem_rd_data,
    output logic              burst_vld,
    output logic [DSIZE-1:0]  burst_rd_data,
    output logic              rd_buf_sel,
    output logic              frame_active,
    output logic              proto_err
);
    state_t            state;
    logic              swap_pend;
    logic [LEN_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] nxt_addr;
    logic [LEN_W-1:0]  nxt_len;
    logic              first, last, inc, apply, last_beat;

    assign inc       = (state == S_DATA) && mem_rd_vld;
    assign apply     = ((state == S_IDLE) && enable) || (state == S_FEND);
    assign last_beat = beat_cnt == mem_rd_len - 1'b1;

    disp_rd_addr_gen #(
        .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) u_addr (
        .clk(clk), .rst_n(rst_n), .clr(apply), .inc(inc), .sel(rd_buf_sel),
        .base_a(base_a), .base_b(base_b), .addr(nxt_addr), .len(nxt_len),
        .first(first), .last(last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mem_rd_req    <= 1'b0;
            mem_rd_addr   <= '0;
            mem_rd_len    <= '0;
            burst_vld     <= 1'b0;
            burst_rd_data <= '0;
            rd_buf_sel    <= 1'b0;
            frame_active  <= 1'b0;
            proto_err     <= 1'b0;
            swap_pend     <= 1'b0;
            beat_cnt      <= '0;
        end else begin
            burst_vld <= inc;
            // a done pulse landing on the boundary cycle is applied and also kept pending
            swap_pend <= apply ? wr_frame_done : (swap_pend | wr_frame_done);
            if (apply && (swap_pend || wr_frame_done))
                rd_buf_sel <= ~rd_buf_sel;
            if (mem_rd_vld && (state != S_DATA))
                proto_err <= 1'b1;
            case (state)
                S_IDLE: if (enable) state <= S_WAIT;
                S_WAIT: begin
                    if (!enable) begin
                        state        <= S_IDLE;
                        frame_active <= 1'b0;
                    end else if (disp_fifo_rdy) begin
                        mem_rd_addr  <= nxt_addr;
                        mem_rd_len   <= nxt_len;
                        mem_rd_req   <= 1'b1;
                        frame_active <= 1'b1;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_rd_ack) begin
                        mem_rd_req <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mem_rd_vld) begin
                        burst_rd_data <= {last, first, mem_rd_data};
                        beat_cnt      <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state <= last ? S_FEND : (enable ? S_WAIT : S_IDLE);
                            if (!last && !enable)
                                frame_active <= 1'b0;
                        end
                    end
                end
                S_FEND: begin
                    frame_active <= 1'b0;
                    state        <= enable ? S_WAIT : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_frame_rd_ctrl.sv
// tb_disp_frame_rd_ctrl: randomized memory timing and buffer bases checked against a frame-level model
module tb_disp_frame_rd_ctrl;
    localparam int FW = 100;
    localparam int BL = 32;
    localparam int AW = 24;
    localparam int LW = 6;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          enable = 0;
    logic [AW-1:0] base_a, base_b;
    logic          wr_frame_done = 0;
    logic          disp_fifo_rdy = 1;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic [LW-1:0] mem_rd_len;
    logic          mem_rd_ack = 0;
    logic          m_vld = 0;
    logic          stray = 0;
    logic          mem_rd_vld;
    logic [31:0]   mem_rd_data = 0;
    logic          burst_vld;
    logic [33:0]   burst_rd_data;
    logic          rd_buf_sel, frame_active, proto_err;

    int          checks = 0;
    int          errors = 0;
    logic [34:0] out_q[$];
    logic [29:0] req_q[$];
    logic        req_d = 0;
    logic [7:0]  salt;

    assign mem_rd_vld = m_vld | stray;
    always #5 clk = ~clk;

    disp_frame_rd_ctrl #(.FRAME_WORDS(FW), .BURST_LEN(BL), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .base_a(base_a), .base_b(base_b),
        .wr_frame_done(wr_frame_done), .disp_fifo_rdy(disp_fifo_rdy),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
        .mem_rd_ack(mem_rd_ack), .mem_rd_vld(mem_rd_vld), .mem_rd_data(mem_rd_data),
        .burst_vld(burst_vld), .burst_rd_data(burst_rd_data), .rd_buf_sel(rd_buf_sel),
        .frame_active(frame_active), .proto_err(proto_err)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {a[7:0] ^ salt, a};
    endfunction

    // every FIFO write is logged with the buffer select seen at that moment
    always @(negedge clk) begin
        if (burst_vld) out_q.push_back({rd_buf_sel, burst_rd_data});
        if (mem_rd_req && !req_d) req_q.push_back({mem_rd_addr, mem_rd_len});
        req_d <= mem_rd_req;
    end

    initial begin
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        forever begin
            @(negedge clk);
            if (mem_rd_req) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                a = mem_rd_addr;
                l = mem_rd_len;
                mem_rd_ack = 1;
                @(negedge clk);
                mem_rd_ack = 0;
                for (int i = 0; i < int'(l); i++) begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    m_vld = 1;
                    mem_rd_data = mem_word(a + AW'(i));
                    @(negedge clk);
                    m_vld = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (out_q.size() < n && t < 3000) begin
            step(1);
            t++;
        end
        chk("wait_words", 64'(out_q.size() >= n), 64'd1);
    endtask

    task automatic check_frame(input int start, input logic [AW-1:0] base, input logic sel, input int n);
        logic [34:0] e;
        for (int i = 0; i < n; i++) begin
            e = {sel, i == FW - 1, i == 0, mem_word(base + AW'(i))};
            chk("frame_word", 64'(out_q[start + i]), 64'(e));
        end
    endtask

    task automatic check_reqs(input int start, input logic [AW-1:0] base, input int n);
        int len;
        logic [29:0] e;
        for (int k = 0; k < n; k++) begin
            len = (FW - BL * k < BL) ? FW - BL * k : BL;
            e = {base + AW'(BL * k), LW'(len)};
            chk("burst_req", 64'(req_q[start + k]), 64'(e));
        end
    endtask

    task automatic check_reset(input string tag);
        chk(tag, 64'({mem_rd_req, mem_rd_addr, mem_rd_len, burst_vld, burst_rd_data,
                      rd_buf_sel, frame_active, proto_err}), 64'd0);
    endtask

    initial begin
        salt   = 8'($urandom);
        base_a = AW'($urandom);
        base_b = AW'($urandom);
        step(3);
        check_reset("reset_outputs");
        rst_n = 1;
        step(3);
        chk("idle_no_req", 64'(mem_rd_req), 64'd0);
        enable = 1;
        wait_words(1);
        disp_fifo_rdy = 0;
        wait_words(32);
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("req_held_off", 64'(mem_rd_req), 64'd0);
        end
        disp_fifo_rdy = 1;
        step(1);
        chk("req_resume", 64'(mem_rd_req), 64'd1);
        chk("frame_active", 64'(frame_active), 64'd1);
        wait_words(40);
        wr_frame_done = 1;
        step(1);
        wr_frame_done = 0;
        wait_words(70);
        wr_frame_done = 1;
        step(1);
        wr_frame_done = 0;
        wait_words(100);
        check_frame(0, base_a, 1'b0, FW);
        check_reqs(0, base_a, 4);
        wait_words(200);
        check_frame(100, base_b, 1'b1, FW);
        check_reqs(4, base_b, 4);
        wait_words(242);
        enable = 0;
        wait_words(264);
        step(30);
        chk("abort_words", 64'(out_q.size()), 64'd264);
        chk("abort_reqs", 64'(req_q.size()), 64'd10);
        chk("abort_no_req", 64'(mem_rd_req), 64'd0);
        check_frame(200, base_b, 1'b1, 64);
        check_reqs(8, base_b, 2);
        wr_frame_done = 1;
        step(1);
        wr_frame_done = 0;
        step(2);
        enable = 1;
        wait_words(361);
        enable = 0;
        wait_words(364);
        step(20);
        check_frame(264, base_a, 1'b0, FW);
        check_reqs(10, base_a, 4);
        chk("end_words", 64'(out_q.size()), 64'd364);
        chk("end_reqs", 64'(req_q.size()), 64'd14);
        chk("end_frame_active", 64'(frame_active), 64'd0);
        chk("proto_clean", 64'(proto_err), 64'd0);
        stray = 1;
        step(1);
        stray = 0;
        step(3);
        chk("stray_no_write", 64'(out_q.size()), 64'd364);
        chk("proto_set", 64'(proto_err), 64'd1);
        step(10);
        chk("proto_sticky", 64'(proto_err), 64'd1);
        rst_n = 0;
        #1;
        check_reset("async_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
